// File: rtl/dd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dd_pkg : shared types and constants for the Dig Dug game logic.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLATED = 2'd1,
    POPPED   = 2'd2,
    DEAD     = 2'd3
  } inflate_state_t;

  localparam logic [2:0] MAX_STAGE = 3'd4;

  localparam logic [7:0] KEY_W     = 8'd26;
  localparam logic [7:0] KEY_S     = 8'd22;
  localparam logic [7:0] KEY_A     = 8'd4;
  localparam logic [7:0] KEY_D     = 8'd7;
  localparam logic [7:0] KEY_SPACE = 8'd44;

  // Subtracting the smaller operand from the larger keeps the result unsigned.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    abs_diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_inflate_rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rise_detect : registered one-cycle pulse on a rising input edge.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rise_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;
  logic rise_q, rise_d;

  always_comb begin
    d_d    = d;
    rise_d = d & ~d_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/enemy_inflate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enemy_inflate : per-enemy pump hit test and inflate/pop state.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module enemy_inflate
  import dd_pkg::*;
#(
  parameter logic [9:0] HIT_RADIUS     = 10'd12,
  parameter logic [5:0] DEFLATE_FRAMES = 6'd30,
  parameter logic [5:0] POP_FRAMES     = 6'd20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       pump_enable,
  input  logic [9:0] Pump_X_Loc,
  input  logic [9:0] Pump_Y_Loc,
  input  logic [9:0] Enemy_X_Loc,
  input  logic [9:0] Enemy_Y_Loc,
  input  logic       respawn,
  output logic [2:0] inflate_stage,
  output logic       enemy_frozen,
  output logic       pop_pulse,
  output logic       is_dead
);

  logic        press;
  logic [10:0] dx, dy;
  logic        hit;
  logic        landed;

  logic           press_q, press_d;
  logic           hit_q, hit_d;
  inflate_state_t state_q, state_d;
  logic [2:0]     stage_q, stage_d;
  logic [5:0]     deflate_cnt_q, deflate_cnt_d;
  logic [5:0]     pop_cnt_q, pop_cnt_d;
  logic           frozen_q, frozen_d;
  logic           pop_q, pop_d;
  logic           dead_q, dead_d;

  rise_detect u_rise_detect (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (pump_enable),
    .rise    (press)
  );

  assign dx     = abs_diff(Pump_X_Loc, Enemy_X_Loc);
  assign dy     = abs_diff(Pump_Y_Loc, Enemy_Y_Loc);
  assign hit    = (dx <= {1'b0, HIT_RADIUS}) && (dy <= {1'b0, HIT_RADIUS});
  assign landed = press_q & hit_q;

  always_comb begin
    press_d       = press;
    hit_d         = hit;
    state_d       = state_q;
    stage_d       = stage_q;
    deflate_cnt_d = deflate_cnt_q;
    pop_cnt_d     = pop_cnt_q;
    pop_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (landed) begin
          stage_d       = 3'd1;
          state_d       = INFLATED;
          deflate_cnt_d = 6'd0;
        end
      end
      INFLATED: begin
        // A landed press takes priority over a coincident frame tick.
        if (landed) begin
          deflate_cnt_d = 6'd0;
          if (stage_q + 3'd1 == MAX_STAGE) begin
            stage_d   = MAX_STAGE;
            pop_d     = 1'b1;
            pop_cnt_d = 6'd0;
            state_d   = POPPED;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end else if (frame_tick) begin
          if (deflate_cnt_q == DEFLATE_FRAMES - 6'd1) begin
            stage_d       = stage_q - 3'd1;
            deflate_cnt_d = 6'd0;
            if (stage_q == 3'd1) state_d = IDLE;
          end else if (deflate_cnt_q != 6'h3F) begin
            deflate_cnt_d = deflate_cnt_q + 6'd1;
          end
        end
      end
      POPPED: begin
        if (frame_tick) begin
          if (pop_cnt_q == POP_FRAMES - 6'd1) begin
            stage_d = 3'd0;
            state_d = DEAD;
          end else if (pop_cnt_q != 6'h3F) begin
            pop_cnt_d = pop_cnt_q + 6'd1;
          end
        end
      end
      DEAD: begin
        if (respawn) begin
          state_d = IDLE;
          stage_d = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = 3'd0;
      end
    endcase

    frozen_d = (stage_d != 3'd0) || (state_d == POPPED);
    dead_d   = (state_d == DEAD);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      press_q       <= 1'b0;
      hit_q         <= 1'b0;
      state_q       <= IDLE;
      stage_q       <= 3'd0;
      deflate_cnt_q <= 6'd0;
      pop_cnt_q     <= 6'd0;
      frozen_q      <= 1'b0;
      pop_q         <= 1'b0;
      dead_q        <= 1'b0;
    end else begin
      press_q       <= press_d;
      hit_q         <= hit_d;
      state_q       <= state_d;
      stage_q       <= stage_d;
      deflate_cnt_q <= deflate_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      frozen_q      <= frozen_d;
      pop_q         <= pop_d;
      dead_q        <= dead_d;
    end
  end

  assign inflate_stage = stage_q;
  assign enemy_frozen  = frozen_q;
  assign pop_pulse     = pop_q;
  assign is_dead       = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_inflate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_enemy_inflate : directed and randomized checks of enemy_inflate.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_enemy_inflate;

  localparam int RADIUS  = 12;
  localparam int DEFLATE = 30;
  localparam int POPLEN  = 20;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, pump_enable, respawn;
  logic [9:0] Pump_X_Loc, Pump_Y_Loc, Enemy_X_Loc, Enemy_Y_Loc;
  logic [2:0] inflate_stage;
  logic       enemy_frozen, pop_pulse, is_dead;

  int n_total = 0;
  int n_fail  = 0;
  int pops_seen = 0;

  // Reference model: mode 0 idle, 1 inflated, 2 popped, 3 dead.
  int m_mode, m_stage, m_defl, m_popc;
  bit m_pop;
  bit pe1, pe2, pe3, hit1;

  enemy_inflate dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .pump_enable   (pump_enable),
    .Pump_X_Loc    (Pump_X_Loc),
    .Pump_Y_Loc    (Pump_Y_Loc),
    .Enemy_X_Loc   (Enemy_X_Loc),
    .Enemy_Y_Loc   (Enemy_Y_Loc),
    .respawn       (respawn),
    .inflate_stage (inflate_stage),
    .enemy_frozen  (enemy_frozen),
    .pop_pulse     (pop_pulse),
    .is_dead       (is_dead)
  );

  always #5 Clk = ~Clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_stage = 0; m_defl = 0; m_popc = 0; m_pop = 0;
    pe1 = 0; pe2 = 0; pe3 = 0; hit1 = 0;
  endtask

  // A press lands two edges after the edge that first samples the key high,
  // provided the pump tip was on target one edge after that first sample.
  task automatic model_edge();
    bit landed, hit_now;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    landed  = pe2 && !pe3 && hit1;
    hit_now = (iabs(int'(Pump_X_Loc) - int'(Enemy_X_Loc)) <= RADIUS) &&
              (iabs(int'(Pump_Y_Loc) - int'(Enemy_Y_Loc)) <= RADIUS);
    m_pop = 0;
    if (m_mode == 0) begin
      if (landed) begin m_stage = 1; m_mode = 1; m_defl = 0; end
    end else if (m_mode == 1) begin
      if (landed) begin
        m_defl = 0;
        if (m_stage + 1 >= 4) begin
          m_stage = 4; m_pop = 1; m_popc = 0; m_mode = 2;
        end else m_stage++;
      end else if (frame_tick) begin
        if (m_defl == DEFLATE - 1) begin
          m_stage--; m_defl = 0;
          if (m_stage == 0) m_mode = 0;
        end else if (m_defl < 63) m_defl++;
      end
    end else if (m_mode == 2) begin
      if (frame_tick) begin
        if (m_popc == POPLEN - 1) begin m_stage = 0; m_mode = 3; end
        else if (m_popc < 63) m_popc++;
      end
    end else begin
      if (respawn) begin m_mode = 0; m_stage = 0; end
    end
    pe3 = pe2; pe2 = pe1; pe1 = pump_enable; hit1 = hit_now;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("stage",  inflate_stage, m_stage);
    chk("frozen", enemy_frozen,  (m_stage != 0 || m_mode == 2) ? 1 : 0);
    chk("pop",    pop_pulse,     m_pop);
    chk("dead",   is_dead,       (m_mode == 3) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    if (pop_pulse === 1'b1) pops_seen++;
    chk_model();
  endtask

  task automatic press_pulse();
    pump_enable = 1'b1; cycle();
    pump_enable = 1'b0; cycle(); cycle(); cycle();
  endtask

  task automatic tick();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle();
  endtask

  task automatic set_pump(input int x, input int y);
    Pump_X_Loc = 10'(x); Pump_Y_Loc = 10'(y);
  endtask

  initial begin
    int pops_before;
    Reset_n = 1'b0; frame_tick = 1'b0; pump_enable = 1'b0; respawn = 1'b0;
    Enemy_X_Loc = 10'd200; Enemy_Y_Loc = 10'd200;
    set_pump(210, 195);
    model_reset();
    #2;
    chk("reset_stage", inflate_stage, 0);
    chk("reset_frozen", enemy_frozen, 0);
    chk("reset_pop", pop_pulse, 0);
    chk("reset_dead", is_dead, 0);
    cycle(); cycle();
    Reset_n = 1'b1;
    cycle();

    // Four presses on target: 1, 2, 3, then pop.
    for (int k = 1; k <= 3; k++) begin
      press_pulse();
      chk("t1_stage", inflate_stage, k);
    end
    pops_before = pops_seen;
    press_pulse();
    chk("t1_pop_count", pops_seen - pops_before, 1);
    chk("t1_stage4", inflate_stage, 4);
    chk("t1_frozen", enemy_frozen, 1);

    // Popped sprite held for the pop period, then dead; respawn revives.
    for (int k = 0; k < POPLEN; k++) tick();
    chk("dead_after_pop", is_dead, 1);
    chk("dead_stage", inflate_stage, 0);
    respawn = 1'b1; cycle(); respawn = 1'b0; cycle();
    chk("respawn_dead", is_dead, 0);
    chk("respawn_frozen", enemy_frozen, 0);

    // Hit radius boundary.
    set_pump(213, 200);
    press_pulse();
    chk("miss_dx13", inflate_stage, 0);
    set_pump(212, 200);
    press_pulse();
    chk("hit_dx12", inflate_stage, 1);

    // Deflation from stage 2.
    press_pulse();
    chk("pre_deflate", inflate_stage, 2);
    for (int k = 0; k < DEFLATE; k++) tick();
    chk("deflate_30", inflate_stage, 1);
    for (int k = 0; k < DEFLATE; k++) tick();
    chk("deflate_60", inflate_stage, 0);
    chk("deflate_frozen", enemy_frozen, 0);

    // A held key lands only once.
    set_pump(205, 190);
    pump_enable = 1'b1;
    for (int k = 0; k < 100; k++) cycle();
    chk("held_key", inflate_stage, 1);
    pump_enable = 1'b0;
    cycle(); cycle();

    // Reset mid-frame at stage 3.
    press_pulse(); press_pulse();
    chk("pre_reset", inflate_stage, 3);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_stage", inflate_stage, 0);
    chk("async_frozen", enemy_frozen, 0);
    chk("async_pop", pop_pulse, 0);
    chk("async_dead", is_dead, 0);
    model_reset();
    cycle();
    Reset_n = 1'b1;
    cycle();
    press_pulse();
    chk("after_reset", inflate_stage, 1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0)
        set_pump($urandom_range(0, 1023), $urandom_range(0, 1023));
      else
        set_pump(200 + $urandom_range(0, 30) - 15, 200 + $urandom_range(0, 30) - 15);
      pump_enable = ($urandom_range(0, 2) == 0);
      frame_tick  = ($urandom_range(0, 3) == 0);
      respawn     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    pump_enable = 1'b0; frame_tick = 1'b0; respawn = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enemy_inflate.md
# enemy_inflate

Per-enemy responder to the player's pump in the Dig Dug game logic. It tests the pump tip position against one enemy's position each clock. Each fresh pump press that lands on the enemy adds one inflation stage, and the enemy deflates over frames when left alone. At full inflation the enemy pops. One instance sits beside each enemy's motion block; its outputs freeze enemy motion, select the inflated sprite, and pulse the score logic.

## Interface
Parameters:
- HIT_RADIUS, 10'd12: maximum per-axis distance, in pixels, between pump tip and enemy centre that counts as a hit.
- DEFLATE_FRAMES, 6'd30: number of frame ticks without a landed press before one stage is removed.
- POP_FRAMES, 6'd20: number of frame ticks the popped sprite is held before the enemy is dead.

Ports:
- Clk  in  1: system clock; all state changes on the rising edge.
- Reset_n  in  1: asynchronous, active-low reset.
- frame_tick  in  1: one-Clk pulse per video frame.
- pump_enable  in  1: high while the fire key is held.
- Pump_X_Loc, Pump_Y_Loc  in  10 each: pump tip centre.
- Enemy_X_Loc, Enemy_Y_Loc  in  10 each: enemy centre.
- respawn  in  1: one-Clk pulse that returns a dead enemy to play.
- inflate_stage  out  3: 0 to 4; drives sprite selection.
- enemy_frozen  out  1: high when inflate_stage is nonzero or state is POPPED.
- pop_pulse  out  1: one-Clk pulse when the enemy pops; goes to score.
- is_dead  out  1: high in DEAD; enemy not drawn and not collidable.

## Operation
- Press detection: pump_enable is registered, and press = pump_enable & ~pump_enable_q. A held key lands at most one stage.
- Hit test:
  - Per axis, dx = |Pump_X_Loc − Enemy_X_Loc|, computed in 11-bit unsigned arithmetic by subtracting the smaller operand from the larger. dy is computed the same way.
  - hit = (dx ≤ HIT_RADIUS) & (dy ≤ HIT_RADIUS).
  - hit is registered; press is delayed one cycle to align with it.
- States, held in inflate_state_t: IDLE, INFLATED, POPPED, DEAD.
- IDLE, with stage 0: a landed press (aligned press & registered hit) sets stage to 1, goes to INFLATED, and clears deflate_cnt.
- INFLATED:
  - A landed press increments stage and clears deflate_cnt.
  - If the increment would make stage 4: set stage to 4, assert pop_pulse for exactly that edge, clear pop_cnt, and go to POPPED.
  - Otherwise, each frame_tick increments deflate_cnt.
  - When deflate_cnt reaches DEFLATE_FRAMES−1 on a tick: decrement stage and clear deflate_cnt. If stage reaches 0, go to IDLE.
- POPPED: presses are ignored. Each frame_tick increments pop_cnt. On the tick where pop_cnt equals POP_FRAMES−1, stage becomes 0 and state goes to DEAD.
- DEAD: respawn goes to IDLE with stage 0. Presses are ignored.
- Counters are 6 bits and saturate rather than wrap.

## Timing
- Reset values: state IDLE, inflate_stage 0, enemy_frozen 0, pop_pulse 0, is_dead 0. All counters and pipeline registers are 0.
- Latency: the edge where pump_enable rises is edge 0. inflate_stage updates at edge 2.
- Simultaneous events:
  - A landed press and frame_tick on the same cycle: the press wins and deflate_cnt clears.
  - respawn outside DEAD is ignored.
  - respawn together with a press in DEAD goes to IDLE only; the press does not land.
- pop_pulse is never asserted on two consecutive cycles.
- Reset asserted mid-operation returns every output to its reset value asynchronously. No pop_pulse is generated.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Package dd_pkg holds:
  - the inflate_state_t enum;
  - the MAX_STAGE = 3'd4 constant;
  - the shared keycode constants (KEY_W 26, KEY_S 22, KEY_A 4, KEY_D 7, KEY_SPACE 44).
- Sub-module rise_detect (Clk, Reset_n, d, rise) generates press. The hit test and FSM are inline.

## Test plan
- Enemy at (200,200), pump at (210,195); pulse pump_enable four times with 3 idle cycles between pulses. Required: stage goes 1, 2, 3, then POPPED. pop_pulse is high for exactly one cycle on the 4th press, and inflate_stage is 4.
- Pump at (213,200) (dx 13): press. Required: stage stays 0 and state stays IDLE. Repeat with pump at (212,200): stage becomes 1.
- Hold pump_enable high for 100 cycles over the enemy. Required: stage is 1 only.
- Stage 2, no presses, 60 frame_ticks. Required: stage 1 after tick 30, stage 0 and IDLE after tick 60.
- After a pop, 20 frame_ticks. Required: is_dead=1. Then pulse respawn: IDLE, is_dead=0.
- Stage 3; drop Reset_n low mid-frame. Required: outputs go to 0 immediately with no pop_pulse. After release, a press lands as stage 1.
